// File: rtl/width_pkg.sv
// Shared types for the width_change / width_split byte path.
package width_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO
  } split_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Pointer-based synchronous FIFO; read data is the registered slot at the read pointer.
// Writes are ignored when full, reads when empty; no same-cycle bypass.
module sync_fifo #(
  parameter  int DW    = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_vld,
  input  logic [DW-1:0] i_wr_dat,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_rd_dat,
  output logic          o_full,
  output logic [AW:0]   o_level
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_cnt;
  logic [AW:0]   r_rd_cnt;
  logic [AW:0]   w_level;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  // Counters carry one extra bit so full and empty stay distinguishable.
  assign w_level = r_wr_cnt - r_rd_cnt;
  assign w_full  = (w_level == (AW+1)'(DEPTH));
  assign w_push  = i_wr_vld && !w_full;
  assign w_pop   = i_rd_en && (w_level != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_push) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_pop)  r_rd_cnt <= r_rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_cnt[AW-1:0]] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[r_rd_cnt[AW-1:0]];
  assign o_full   = w_full;
  assign o_level  = w_level;

endmodule

// File: rtl/width_split.sv
// Buffers 2*WIDTH words and re-serialises them upper byte first; first byte valid 2 cycles after din_vld.
// dout holds under !dout_rdy; input has no backpressure, so words arriving while full are dropped into ovf.
module width_split
  import width_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] din,
  input  logic               din_vld,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_vld,
  input  logic               dout_rdy,
  output logic               full,
  output logic [AW:0]        level,
  output logic               ovf
);

  split_state_t       r_state;
  split_state_t       w_state_nxt;
  logic               w_pop;
  logic [2*WIDTH-1:0] w_fifo_dat;
  logic               w_full;
  logic [AW:0]        w_level;
  logic [2*WIDTH-1:0] r_wreg;
  logic [2*WIDTH-1:0] w_wreg_nxt;
  logic [WIDTH-1:0]   r_dout;
  logic [WIDTH-1:0]   w_dout_nxt;
  logic               r_dout_vld;
  logic               w_dout_vld_nxt;
  logic               r_ovf;

  sync_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_wr_vld (din_vld),
    .i_wr_dat (din),
    .i_rd_en  (w_pop),
    .o_rd_dat (w_fifo_dat),
    .o_full   (w_full),
    .o_level  (w_level)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_dout_nxt     = '0;
    w_dout_vld_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_level != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = HI;
        end
      end
      HI: begin
        if (dout_rdy) w_state_nxt = LO;
      end
      LO: begin
        if (dout_rdy) begin
          if (w_level != '0) begin
            w_pop       = 1'b1;
            w_state_nxt = HI;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Output byte is precomputed from the next state so dout/dout_vld come straight from flops.
    w_wreg_nxt = w_pop ? w_fifo_dat : r_wreg;
    case (w_state_nxt)
      HI: begin
        w_dout_nxt     = w_wreg_nxt[2*WIDTH-1:WIDTH];
        w_dout_vld_nxt = 1'b1;
      end
      LO: begin
        w_dout_nxt     = w_wreg_nxt[WIDTH-1:0];
        w_dout_vld_nxt = 1'b1;
      end
      default: begin
        w_dout_nxt     = '0;
        w_dout_vld_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wreg     <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wreg     <= w_wreg_nxt;
      r_dout     <= w_dout_nxt;
      r_dout_vld <= w_dout_vld_nxt;
      if (din_vld && w_full) r_ovf <= 1'b1;
    end
  end

  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;
  assign full     = w_full;
  assign level    = w_level;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_width_split.sv
// Directed bench for width_split: stimulus pushes expected bytes, a negedge monitor pops and compares.
module tb_width_split;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        din_vld;
  logic [7:0]  dout;
  logic        dout_vld;
  logic        dout_rdy;
  logic        full;
  logic [2:0]  level;
  logic        ovf;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_dout = '0;

  width_split #(.WIDTH(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .full     (full),
    .level    (level),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: bytes accepted at the next rising edge are compared here.
  always @(negedge clk) begin
    if (prev_stall) begin
      check("hold_vld", 32'(dout_vld), 32'd1);
      check("hold_dat", 32'(dout), 32'(prev_dout));
    end
    if (dout_vld && dout_rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_byte: got %0h, expected none", dout);
      end else begin
        check("byte", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
    prev_stall = dout_vld && !dout_rdy && !rst;
    prev_dout  = dout;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input bit keep);
    din     = w;
    din_vld = 1'b1;
    if (keep) begin
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    tick();
    din_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    din_vld  = 1'b0;
    dout_rdy = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    dout_rdy = 1'b1;
    while ((exp_q.size() != 0 || dout_vld) && k < 300) begin
      tick();
      k++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("drain_vld", 32'(dout_vld), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bp_bytes [6];
    bp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    din = '0;
    din_vld = 1'b0;
    dout_rdy = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_dout", 32'(dout), 32'h0);
    check("rst_vld", 32'(dout_vld), 32'h0);
    check("rst_full", 32'(full), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);

    // Single word: bytes appear two cycles after the din_vld cycle.
    dout_rdy = 1'b1;
    send_word(16'hA55A, 1'b1);
    check("sw_lat0_vld", 32'(dout_vld), 32'd0);
    tick();
    check("sw_hi_vld", 32'(dout_vld), 32'd1);
    check("sw_hi", 32'(dout), 32'hA5);
    tick();
    check("sw_lo_vld", 32'(dout_vld), 32'd1);
    check("sw_lo", 32'(dout), 32'h5A);
    tick();
    check("sw_end_vld", 32'(dout_vld), 32'd0);
    check("sw_level", 32'(level), 32'd0);
    drain();

    // Backpressure: first byte held, remaining two words queued.
    dout_rdy = 1'b0;
    send_word(16'h0102, 1'b1);
    send_word(16'h0304, 1'b1);
    send_word(16'h0506, 1'b1);
    check("bp_level", 32'(level), 32'd2);
    check("bp_hold", 32'(dout), 32'h01);
    tick();
    check("bp_hold2", 32'(dout), 32'h01);
    dout_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("bp_stream_vld", 32'(dout_vld), 32'd1);
      check("bp_stream", 32'(dout), 32'(bp_bytes[i]));
      tick();
    end
    check("bp_done_vld", 32'(dout_vld), 32'd0);
    check("bp_ovf", 32'(ovf), 32'd0);
    drain();

    // Overflow: one word in wreg, four in FIFO, sixth dropped.
    dout_rdy = 1'b0;
    for (int i = 0; i < 6; i++)
      send_word(16'h1112 + 16'(i) * 16'h0202, i < 5);
    check("ov_full", 32'(full), 32'd1);
    check("ov_level", 32'(level), 32'd4);
    check("ov_ovf", 32'(ovf), 32'd1);
    drain();
    check("ov_sticky", 32'(ovf), 32'd1);
    check("ov_full_after", 32'(full), 32'd0);

    // Reset while in LO with two words queued.
    dout_rdy = 1'b0;
    send_word(16'h2122, 1'b1);
    send_word(16'h2324, 1'b1);
    send_word(16'h2526, 1'b1);
    dout_rdy = 1'b1;
    tick();
    dout_rdy = 1'b0;
    check("mr_lo_byte", 32'(dout), 32'h22);
    check("mr_level", 32'(level), 32'd2);
    check("mr_ovf_before", 32'(ovf), 32'd1);
    do_reset();
    check("mr_vld", 32'(dout_vld), 32'd0);
    check("mr_level0", 32'(level), 32'd0);
    check("mr_full", 32'(full), 32'd0);
    check("mr_ovf", 32'(ovf), 32'd0);
    dout_rdy = 1'b1;
    send_word(16'h7788, 1'b1);
    tick();
    check("mr_post_hi", 32'(dout), 32'h77);
    tick();
    check("mr_post_lo", 32'(dout), 32'h88);
    drain();

    // Wrap-around at the source's maximum rate.
    do_reset();
    dout_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) send_word(16'h1357 + 16'(i) * 16'h0B1D, 1'b1);
      else tick();
      check("wr_level_max", 32'(level <= 3'd1), 32'd1);
    end
    drain();
    check("wr_ovf", 32'(ovf), 32'd0);

    // Random ready; backlog capped so that no word can legitimately be dropped.
    do_reset();
    for (int i = 0; i < 80; i++) begin
      dout_rdy = (exp_q.size() >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
      if (i % 4 == 0) send_word(16'hC0DE ^ (16'(i) * 16'h0421), 1'b1);
      else tick();
    end
    drain();
    check("rr_ovf", 32'(ovf), 32'd0);

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
